// File: rtl/pzcorebus_csrbus_response_timeout.sv
// CSR-bus response watchdog: forwards CSR commands, tracks the single outstanding
// non-posted command and answers with an error response if the target stays silent.

package pzcorebus_pkg;

  typedef enum logic [1:0] {
    PZCOREBUS_CSR_PROFILE      = 2'd0,
    PZCOREBUS_MEMORY_H_PROFILE = 2'd1,
    PZCOREBUS_MEMORY_L_PROFILE = 2'd2
  } pzcorebus_profile;

  typedef enum logic [2:0] {
    PZCOREBUS_NULL_COMMAND     = 3'b000,
    PZCOREBUS_WRITE            = 3'b001,
    PZCOREBUS_WRITE_NON_POSTED = 3'b011,
    PZCOREBUS_READ             = 3'b101
  } pzcorebus_command_type;

  typedef enum logic [1:0] {
    PZCOREBUS_NULL_RESPONSE       = 2'b00,
    PZCOREBUS_RESPONSE            = 2'b01,
    PZCOREBUS_RESPONSE_WITH_DATA  = 2'b10
  } pzcorebus_response_type;

  typedef struct packed {
    pzcorebus_profile profile;
    int               id_width;
    int               address_width;
    int               data_width;
    int               length_width;
    int               request_info_width;
    int               response_info_width;
  } pzcorebus_config;

  localparam pzcorebus_config PZCOREBUS_DEFAULT_CSR_CONFIG = '{
    profile:             PZCOREBUS_CSR_PROFILE,
    id_width:            4,
    address_width:       16,
    data_width:          32,
    length_width:        4,
    request_info_width:  1,
    response_info_width: 1
  };

  function automatic logic is_csr_profile(input pzcorebus_config cfg);
    return cfg.profile == PZCOREBUS_CSR_PROFILE;
  endfunction

  function automatic logic is_non_posted_command(input pzcorebus_command_type cmd);
    return (cmd == PZCOREBUS_READ) || (cmd == PZCOREBUS_WRITE_NON_POSTED);
  endfunction

endpackage

interface pzcorebus_if #(
  parameter pzcorebus_pkg::pzcorebus_config BUS_CONFIG = pzcorebus_pkg::PZCOREBUS_DEFAULT_CSR_CONFIG
);
  localparam int IW  = BUS_CONFIG.id_width;
  localparam int AW  = BUS_CONFIG.address_width;
  localparam int DW  = BUS_CONFIG.data_width;
  localparam int BW  = BUS_CONFIG.data_width / 8;
  localparam int LW  = BUS_CONFIG.length_width;
  localparam int QIW = BUS_CONFIG.request_info_width;
  localparam int RIW = BUS_CONFIG.response_info_width;

  logic                                  mcmd_valid;
  logic                                  scmd_accept;
  pzcorebus_pkg::pzcorebus_command_type  mcmd;
  logic [IW-1:0]                         mid;
  logic [AW-1:0]                         maddr;
  logic [LW-1:0]                         mlength;
  logic [QIW-1:0]                        minfo;
  logic [DW-1:0]                         mdata;
  logic [BW-1:0]                         mdata_byteen;
  logic                                  mdata_valid;
  logic                                  mdata_last;
  logic                                  sresp_valid;
  logic                                  mresp_accept;
  pzcorebus_pkg::pzcorebus_response_type sresp;
  logic [IW-1:0]                         sid;
  logic                                  serror;
  logic [DW-1:0]                         sdata;
  logic [RIW-1:0]                        sinfo;
  logic [BW-1:0]                         sresp_uniten;
  logic                                  sresp_last;

  modport master (
    output mcmd_valid, input scmd_accept,
    output mcmd, mid, maddr, mlength, minfo, mdata, mdata_byteen, mdata_valid, mdata_last,
    input  sresp_valid, output mresp_accept,
    input  sresp, sid, serror, sdata, sinfo, sresp_uniten, sresp_last
  );

  modport slave (
    input  mcmd_valid, output scmd_accept,
    input  mcmd, mid, maddr, mlength, minfo, mdata, mdata_byteen, mdata_valid, mdata_last,
    output sresp_valid, input mresp_accept,
    output sresp, sid, serror, sdata, sinfo, sresp_uniten, sresp_last
  );
endinterface

module pzcorebus_csrbus_response_timeout
  import pzcorebus_pkg::*;
#(
  parameter pzcorebus_config                    BUS_CONFIG = PZCOREBUS_DEFAULT_CSR_CONFIG,
  parameter int unsigned                        TIMEOUT    = 1024,
  parameter logic [BUS_CONFIG.data_width-1:0]   ERROR_DATA = '0
)(
  input  logic        i_clk,
  input  logic        i_rst_n,
  pzcorebus_if.slave  slave_if,
  pzcorebus_if.master master_if,
  output logic        o_timeout
);
  localparam int IW = BUS_CONFIG.id_width;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit ENABLED = (TIMEOUT != 0);
  localparam logic [CW-1:0] LAST_COUNT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT     = 2'd1;
  localparam logic [1:0] ERR_RESP = 2'd2;
  localparam logic [1:0] DRAIN    = 2'd3;

  logic [1:0]    state;
  logic [1:0]    next_state;
  logic [CW-1:0] count;
  logic [IW-1:0] captured_id;
  logic          is_read;
  logic          late_resp_seen;
  logic          down_accept;
  logic          up_valid;
  logic          cmd_np_ack;
  logic          master_resp_ack;
  logic          slave_resp_ack;
  logic          unused_inputs;

  assign unused_inputs = ^{slave_if.mlength, slave_if.mdata_valid, slave_if.mdata_last,
                           master_if.sresp_uniten, master_if.sresp_last};

  assign cmd_np_ack      = (state == IDLE) && slave_if.mcmd_valid && master_if.scmd_accept &&
                           is_non_posted_command(slave_if.mcmd);
  assign master_resp_ack = master_if.sresp_valid && down_accept;
  assign slave_resp_ack  = up_valid && slave_if.mresp_accept;

  // Command path: fields always flow through, the handshake only while idle.
  always_comb begin
    master_if.mcmd         = slave_if.mcmd;
    master_if.mid          = slave_if.mid;
    master_if.maddr        = slave_if.maddr;
    master_if.minfo        = slave_if.minfo;
    master_if.mdata        = slave_if.mdata;
    master_if.mdata_byteen = slave_if.mdata_byteen;
    master_if.mlength      = '0;
    master_if.mdata_valid  = 1'b0;
    master_if.mdata_last   = 1'b0;
    if (state == IDLE) begin
      master_if.mcmd_valid  = slave_if.mcmd_valid;
      slave_if.scmd_accept  = master_if.scmd_accept;
    end else begin
      master_if.mcmd_valid  = 1'b0;
      slave_if.scmd_accept  = 1'b0;
    end
  end

  // Response path: pass-through, synthesized error response, or silent drain.
  always_comb begin
    up_valid              = 1'b0;
    down_accept           = 1'b0;
    slave_if.sresp        = master_if.sresp;
    slave_if.sid          = master_if.sid;
    slave_if.serror       = master_if.serror;
    slave_if.sdata        = master_if.sdata;
    slave_if.sinfo        = master_if.sinfo;
    slave_if.sresp_uniten = '0;
    slave_if.sresp_last   = 1'b0;
    case (state)
      IDLE, WAIT: begin
        up_valid    = master_if.sresp_valid;
        down_accept = slave_if.mresp_accept;
      end
      ERR_RESP: begin
        up_valid        = 1'b1;
        down_accept     = 1'b1;
        slave_if.sid    = captured_id;
        slave_if.serror = 1'b1;
        slave_if.sinfo  = '0;
        if (is_read) begin
          slave_if.sresp = PZCOREBUS_RESPONSE_WITH_DATA;
          slave_if.sdata = ERROR_DATA;
        end else begin
          slave_if.sresp = PZCOREBUS_RESPONSE;
          slave_if.sdata = '0;
        end
      end
      DRAIN: begin
        up_valid        = 1'b0;
        down_accept     = 1'b1;
        slave_if.sresp  = PZCOREBUS_NULL_RESPONSE;
        slave_if.sid    = '0;
        slave_if.serror = 1'b0;
        slave_if.sdata  = '0;
        slave_if.sinfo  = '0;
      end
      default: begin
        up_valid    = 1'b0;
        down_accept = 1'b0;
      end
    endcase
    slave_if.sresp_valid   = up_valid;
    master_if.mresp_accept = down_accept;
  end

  // Next-state logic; a genuine response beats timer expiry in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (ENABLED && cmd_np_ack) begin
          next_state = WAIT;
        end else begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        if (master_resp_ack) begin
          next_state = IDLE;
        end else if (count == LAST_COUNT) begin
          next_state = ERR_RESP;
        end else begin
          next_state = WAIT;
        end
      end
      ERR_RESP: begin
        if (slave_resp_ack) begin
          next_state = (late_resp_seen || master_resp_ack) ? IDLE : DRAIN;
        end else begin
          next_state = ERR_RESP;
        end
      end
      DRAIN: begin
        if (master_resp_ack) begin
          next_state = IDLE;
        end else begin
          next_state = DRAIN;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Expiry pulse is raised in the last waiting cycle, unless the response lands then.
  always_comb begin
    if ((state == WAIT) && (count == LAST_COUNT) && !master_resp_ack) begin
      o_timeout = 1'b1;
    end else begin
      o_timeout = 1'b0;
    end
  end

  // State register and outstanding-command bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      count          <= '0;
      captured_id    <= '0;
      is_read        <= 1'b0;
      late_resp_seen <= 1'b0;
    end else begin
      state <= next_state;
      if (cmd_np_ack) begin
        count       <= '0;
        captured_id <= slave_if.mid;
        is_read     <= (slave_if.mcmd == PZCOREBUS_READ);
      end else if ((state == WAIT) && !master_resp_ack) begin
        count <= count + CW'(1);
      end
      if (state == WAIT) begin
        late_resp_seen <= 1'b0;
      end else if ((state == ERR_RESP) && master_resp_ack) begin
        late_resp_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pzcorebus_csrbus_response_timeout.sv
// Directed bench for the CSR response watchdog; expected responses go through a scoreboard queue.

module tb_pzcorebus_csrbus_response_timeout;
  import pzcorebus_pkg::*;

  localparam pzcorebus_config CFG = '{
    profile: PZCOREBUS_CSR_PROFILE, id_width: 4, address_width: 16, data_width: 32,
    length_width: 4, request_info_width: 2, response_info_width: 2
  };
  localparam int unsigned TIMEOUT  = 8;
  localparam logic [31:0] ERR_DATA = 32'hBADC_0FFE;

  typedef struct {
    logic [1:0]  sresp;
    logic [3:0]  sid;
    logic        serror;
    logic [31:0] sdata;
  } resp_t;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  o_timeout;
  int    checks = 0;
  int    errors = 0;
  resp_t exp_q[$];
  resp_t exp_r;

  pzcorebus_if #(.BUS_CONFIG(CFG)) up_if();
  pzcorebus_if #(.BUS_CONFIG(CFG)) down_if();

  pzcorebus_csrbus_response_timeout #(
    .BUS_CONFIG (CFG),
    .TIMEOUT    (TIMEOUT),
    .ERROR_DATA (ERR_DATA)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .slave_if  (up_if),
    .master_if (down_if),
    .o_timeout (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    up_if.mcmd_valid       = 1'b0;
    up_if.mcmd             = PZCOREBUS_NULL_COMMAND;
    up_if.mid              = '0;
    up_if.maddr            = '0;
    up_if.mlength          = '0;
    up_if.minfo            = '0;
    up_if.mdata            = '0;
    up_if.mdata_byteen     = '0;
    up_if.mdata_valid      = 1'b0;
    up_if.mdata_last       = 1'b0;
    up_if.mresp_accept     = 1'b1;
    down_if.scmd_accept    = 1'b1;
    down_if.sresp_valid    = 1'b0;
    down_if.sresp          = PZCOREBUS_NULL_RESPONSE;
    down_if.sid            = '0;
    down_if.serror         = 1'b0;
    down_if.sdata          = '0;
    down_if.sinfo          = '0;
    down_if.sresp_uniten   = '0;
    down_if.sresp_last     = 1'b0;
  endtask

  task automatic send_cmd(input pzcorebus_command_type c, input logic [3:0] id,
                          input logic [15:0] a, input logic [31:0] d);
    up_if.mcmd         = c;
    up_if.mid          = id;
    up_if.maddr        = a;
    up_if.mdata        = d;
    up_if.mdata_byteen = 4'hF;
    up_if.minfo        = 2'b10;
    up_if.mcmd_valid   = 1'b1;
  endtask

  task automatic target_resp(input pzcorebus_response_type r, input logic [3:0] id,
                             input logic [31:0] d, input logic err);
    down_if.sresp       = r;
    down_if.sid         = id;
    down_if.sdata       = d;
    down_if.serror      = err;
    down_if.sinfo       = 2'b01;
    down_if.sresp_valid = 1'b1;
  endtask

  task automatic push_exp(input pzcorebus_response_type r, input logic [3:0] id,
                          input logic err, input logic [31:0] d);
    resp_t e;
    e.sresp  = r;
    e.sid    = id;
    e.serror = err;
    e.sdata  = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every upstream response handshake is matched against the queue head.
  always @(negedge clk) begin
    if (rst_n && up_if.sresp_valid && up_if.mresp_accept) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 64'(up_if.sresp_valid), 64'd0);
      end else begin
        exp_r = exp_q.pop_front();
        check("resp_type",  64'(up_if.sresp),  64'(exp_r.sresp));
        check("resp_id",    64'(up_if.sid),    64'(exp_r.sid));
        check("resp_error", 64'(up_if.serror), 64'(exp_r.serror));
        check("resp_data",  64'(up_if.sdata),  64'(exp_r.sdata));
        check("resp_last",  64'({up_if.sresp_last, up_if.sresp_uniten}), 64'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle_bus();
    #2;
    check("rst_timeout",     64'(o_timeout), 64'd0);
    check("rst_scmd_accept", 64'(up_if.scmd_accept), 64'd1);
    check("rst_sresp_valid", 64'(up_if.sresp_valid), 64'd0);
    check("rst_mcmd_valid",  64'(down_if.mcmd_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Read answered by the target after a few cycles
    send_cmd(PZCOREBUS_READ, 4'd3, 16'h0010, 32'd0);
    @(negedge clk);
    check("t1_mcmd_valid", 64'(down_if.mcmd_valid), 64'd1);
    check("t1_maddr",      64'(down_if.maddr), 64'h10);
    check("t1_mid",        64'(down_if.mid), 64'd3);
    check("t1_mcmd",       64'(down_if.mcmd), 64'(PZCOREBUS_READ));
    check("t1_unused_cmd", 64'({down_if.mlength, down_if.mdata_valid, down_if.mdata_last}), 64'd0);
    tick();
    send_cmd(PZCOREBUS_WRITE, 4'd1, 16'h0099, 32'd7);
    @(negedge clk);
    check("t1_wait_accept", 64'(up_if.scmd_accept), 64'd0);
    check("t1_wait_mvalid", 64'(down_if.mcmd_valid), 64'd0);
    up_if.mcmd_valid = 1'b0;
    repeat (4) tick();
    target_resp(PZCOREBUS_RESPONSE_WITH_DATA, 4'd3, 32'h0000_DEAD, 1'b0);
    push_exp(PZCOREBUS_RESPONSE_WITH_DATA, 4'd3, 1'b0, 32'h0000_DEAD);
    @(negedge clk);
    check("t1_sinfo",   64'(up_if.sinfo), 64'd1);
    check("t1_timeout", 64'(o_timeout), 64'd0);
    tick();
    down_if.sresp_valid = 1'b0;
    @(negedge clk);
    check("t1_idle_accept", 64'(up_if.scmd_accept), 64'd1);

    // Read with a silent target: timeout, error response, then a late response drained
    tick();
    send_cmd(PZCOREBUS_READ, 4'd5, 16'h0020, 32'd0);
    tick();
    up_if.mcmd_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("t2_timeout_pulse", 64'(o_timeout), 64'(c == 8));
      @(posedge clk);
      #1;
    end
    push_exp(PZCOREBUS_RESPONSE_WITH_DATA, 4'd5, 1'b1, ERR_DATA);
    @(negedge clk);
    check("t2_timeout_clear", 64'(o_timeout), 64'd0);
    tick();
    up_if.mresp_accept = 1'b0;
    @(negedge clk);
    check("t2_drain_valid",  64'(up_if.sresp_valid), 64'd0);
    check("t2_drain_maccpt", 64'(down_if.mresp_accept), 64'd1);
    check("t2_drain_saccpt", 64'(up_if.scmd_accept), 64'd0);
    repeat (10) tick();
    target_resp(PZCOREBUS_RESPONSE_WITH_DATA, 4'd5, 32'h5555_5555, 1'b0);
    @(negedge clk);
    check("t2_late_hidden", 64'(up_if.sresp_valid), 64'd0);
    tick();
    down_if.sresp_valid = 1'b0;
    up_if.mresp_accept  = 1'b1;
    @(negedge clk);
    check("t2_back_idle", 64'(up_if.scmd_accept), 64'd1);

    // Response landing exactly on the expiry cycle wins
    tick();
    send_cmd(PZCOREBUS_READ, 4'd6, 16'h0030, 32'd0);
    tick();
    up_if.mcmd_valid = 1'b0;
    repeat (7) tick();
    target_resp(PZCOREBUS_RESPONSE_WITH_DATA, 4'd6, 32'h0000_1234, 1'b0);
    push_exp(PZCOREBUS_RESPONSE_WITH_DATA, 4'd6, 1'b0, 32'h0000_1234);
    @(negedge clk);
    check("t3_no_timeout", 64'(o_timeout), 64'd0);
    tick();
    down_if.sresp_valid = 1'b0;
    @(negedge clk);
    check("t3_idle_accept", 64'(up_if.scmd_accept), 64'd1);
    repeat (3) tick();

    // Non-posted write timeout with upstream back-pressure, then a command offered in DRAIN
    send_cmd(PZCOREBUS_WRITE_NON_POSTED, 4'd9, 16'h0030, 32'hCAFE_0001);
    @(negedge clk);
    check("t4_mdata",   64'(down_if.mdata), 64'hCAFE_0001);
    check("t4_byteen",  64'(down_if.mdata_byteen), 64'hF);
    tick();
    up_if.mcmd_valid   = 1'b0;
    up_if.mresp_accept = 1'b0;
    repeat (7) tick();
    @(negedge clk);
    check("t4_timeout", 64'(o_timeout), 64'd1);
    tick();
    send_cmd(PZCOREBUS_WRITE, 4'd1, 16'h0040, 32'h0000_0011);
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      check("t4_hold_valid", 64'(up_if.sresp_valid), 64'd1);
      check("t4_hold_type",  64'(up_if.sresp), 64'(PZCOREBUS_RESPONSE));
      check("t4_hold_id",    64'(up_if.sid), 64'd9);
      check("t4_hold_err",   64'(up_if.serror), 64'd1);
      check("t4_hold_data",  64'(up_if.sdata), 64'd0);
      check("t4_hold_info",  64'(up_if.sinfo), 64'd0);
      check("t4_hold_block", 64'({up_if.scmd_accept, down_if.mcmd_valid}), 64'd0);
      tick();
    end
    push_exp(PZCOREBUS_RESPONSE, 4'd9, 1'b1, 32'd0);
    up_if.mresp_accept = 1'b1;
    tick();
    @(negedge clk);
    check("t4_drain_block", 64'({up_if.scmd_accept, down_if.mcmd_valid}), 64'd0);
    check("t4_drain_valid", 64'(up_if.sresp_valid), 64'd0);
    tick();
    target_resp(PZCOREBUS_RESPONSE, 4'd9, 32'd0, 1'b0);
    @(negedge clk);
    check("t4_late_block", 64'(up_if.scmd_accept), 64'd0);
    tick();
    down_if.sresp_valid = 1'b0;
    @(negedge clk);
    check("t4_cmd_pass",   64'(down_if.mcmd_valid), 64'd1);
    check("t4_cmd_accept", 64'(up_if.scmd_accept), 64'd1);
    check("t4_cmd_addr",   64'(down_if.maddr), 64'h40);
    tick();
    up_if.mcmd_valid = 1'b0;

    // Late response during the error response: straight back to IDLE
    send_cmd(PZCOREBUS_READ, 4'd7, 16'h0050, 32'd0);
    tick();
    up_if.mcmd_valid   = 1'b0;
    up_if.mresp_accept = 1'b0;
    repeat (8) tick();
    target_resp(PZCOREBUS_RESPONSE_WITH_DATA, 4'd7, 32'h7777_7777, 1'b0);
    @(negedge clk);
    check("t5_err_maccept", 64'(down_if.mresp_accept), 64'd1);
    check("t5_err_id",      64'(up_if.sid), 64'd7);
    check("t5_err_data",    64'(up_if.sdata), 64'(ERR_DATA));
    tick();
    down_if.sresp_valid = 1'b0;
    push_exp(PZCOREBUS_RESPONSE_WITH_DATA, 4'd7, 1'b1, ERR_DATA);
    up_if.mresp_accept = 1'b1;
    tick();
    @(negedge clk);
    check("t5_direct_idle", 64'(up_if.scmd_accept), 64'd1);
    tick();

    // Back-to-back posted writes at full rate
    for (int i = 0; i < 4; i++) begin
      send_cmd(PZCOREBUS_WRITE, 4'(i), 16'h0100 + 16'(i), 32'h0000_00A0 + 32'(i));
      @(negedge clk);
      check("t6_mvalid", 64'(down_if.mcmd_valid), 64'd1);
      check("t6_maddr",  64'(down_if.maddr), 64'h100 + 64'(i));
      check("t6_mdata",  64'(down_if.mdata), 64'hA0 + 64'(i));
      check("t6_accept", 64'(up_if.scmd_accept), 64'd1);
      tick();
    end
    up_if.mcmd_valid = 1'b0;
    repeat (9) tick();
    @(negedge clk);
    check("t6_no_timer", 64'(o_timeout), 64'd0);
    check("t6_idle",     64'(up_if.scmd_accept), 64'd1);
    tick();

    // Reset while waiting with count 6, then a normal read
    send_cmd(PZCOREBUS_READ, 4'd2, 16'h0060, 32'd0);
    tick();
    up_if.mcmd_valid = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check("t7_rst_timeout", 64'(o_timeout), 64'd0);
    check("t7_rst_accept",  64'(up_if.scmd_accept), 64'd1);
    check("t7_rst_valid",   64'(up_if.sresp_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send_cmd(PZCOREBUS_READ, 4'd4, 16'h0070, 32'd0);
    tick();
    up_if.mcmd_valid = 1'b0;
    repeat (2) tick();
    target_resp(PZCOREBUS_RESPONSE_WITH_DATA, 4'd4, 32'h0000_BEEF, 1'b0);
    push_exp(PZCOREBUS_RESPONSE_WITH_DATA, 4'd4, 1'b0, 32'h0000_BEEF);
    tick();
    down_if.sresp_valid = 1'b0;
    @(negedge clk);
    check("t7_after_idle", 64'(up_if.scmd_accept), 64'd1);
    repeat (2) tick();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
